cred_auth_ctrl: RTL and testbench

Parametrised credential authentication controller for the bomb-defusal console. It takes a two-step login from the shaped button and switch inputs: first a user ID, then a password. The password is checked against a synchronous credential ROM indexed by user ID. The block adds what the single-user compare lacks: a configurable user count, failed-attempt counting with timed lockout, a password-entry timeout, and explicit logout. Its outputs drive the user 7-segment display and the arming logic.

---
 rtl/cred_auth_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cred_auth_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cred_auth_ctrl.sv
// Credential authentication controller: two-step login (user ID, then
// password) checked against a synchronous credential ROM, with
// consecutive-failure counting, timed lockout, password-entry timeout
// and explicit logout.
//
// Handshake: enter and logout are single-cycle strobes.
// - enter is acted on only in IDLE and WAIT_PW.
// - logout is acted on only in GRANTED.
// - The ROM is addressed continuously by the latched ID.
// - rom_data is valid one cycle after rom_addr is presented.
module cred_auth_ctrl #(
  parameter int CRED_W         = 8,
  parameter int NUM_USERS      = 8,
  parameter int ADDR_W         = 3,
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter,
  input  logic [CRED_W-1:0] cred_in,
  input  logic              logout,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CRED_W-1:0] rom_data,
  output logic [ADDR_W-1:0] user_id,
  output logic              logged_in,
  output logic              auth_fail,
  output logic              locked,
  output logic [3:0]        fail_cnt,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_PW = 3'd1,
    S_FETCH   = 3'd2,
    S_CMP     = 3'd3,
    S_GRANTED = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] id_q, id_d;
  logic [CRED_W-1:0] pw_q, pw_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic [3:0]        fail_q, fail_d;
  logic              afail_q, afail_d;
  logic              id_valid;
  logic              fail_act;
  logic [3:0]        fail_inc;

  // An ID is valid only if the bits above the address field are zero
  // and the address is below the configured user count.
  assign id_valid = (cred_in[CRED_W-1:ADDR_W] == '0) &&
                    ({1'b0, cred_in[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_USERS));

  // Saturating increment of the consecutive failure count.
  assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  // Next-state, datapath and failure handling.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pw_d     = pw_q;
    tmr_d    = tmr_q;
    lock_d   = lock_q;
    fail_d   = fail_q;
    afail_d  = 1'b0;
    fail_act = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enter) begin
          if (id_valid) begin
            id_d    = cred_in[ADDR_W-1:0];
            tmr_d   = '0;
            state_d = S_WAIT_PW;
          end else begin
            fail_act = 1'b1;
          end
        end
      end
      S_WAIT_PW: begin
        // A password arriving on the final allowed cycle beats the timeout.
        if (enter) begin
          pw_d    = cred_in;
          state_d = S_FETCH;
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_FETCH: state_d = S_CMP;
      S_CMP: begin
        if (rom_data == pw_q) begin
          fail_d  = 4'd0;
          state_d = S_GRANTED;
        end else begin
          fail_act = 1'b1;
        end
      end
      S_GRANTED: begin
        if (logout) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_q == LW'(LOCK_CYCLES - 1)) begin
          fail_d  = 4'd0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail_act) begin
      afail_d = 1'b1;
      fail_d  = fail_inc;
      if (fail_inc == 4'(MAX_FAILS)) begin
        lock_d  = '0;
        state_d = S_LOCKOUT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and datapath registers; reset drops any pending failure pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      pw_q    <= '0;
      tmr_q   <= '0;
      lock_q  <= '0;
      fail_q  <= 4'd0;
      afail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pw_q    <= pw_d;
      tmr_q   <= tmr_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
      afail_q <= afail_d;
    end
  end

  assign rom_addr  = id_q;
  assign logged_in = (state_q == S_GRANTED);
  assign user_id   = (state_q == S_GRANTED) ? id_q : '0;
  assign auth_fail = afail_q;
  assign locked    = (state_q == S_LOCKOUT);
  assign fail_cnt  = fail_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_CMP);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cred_auth_ctrl.sv
// Directed bench for cred_auth_ctrl: 4 users, 3-strike lockout of 20
// cycles, 50-cycle password timeout, fixed credential ROM.
module tb_cred_auth_ctrl;

  localparam int CW = 8;
  localparam int AW = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_CMP = 3'd3;
  localparam logic [2:0] ST_GRANT = 3'd4;
  localparam logic [2:0] ST_LOCK = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enter = 1'b0;
  logic [CW-1:0] cred_in = '0;
  logic          logout = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_data;
  logic [AW-1:0] user_id;
  logic          logged_in;
  logic          auth_fail;
  logic          locked;
  logic [3:0]    fail_cnt;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic seen_fail;

  cred_auth_ctrl #(
    .CRED_W(CW), .NUM_USERS(4), .ADDR_W(AW), .MAX_FAILS(3),
    .LOCK_CYCLES(20), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .enter(enter), .cred_in(cred_in), .logout(logout),
    .rom_addr(rom_addr), .rom_data(rom_data), .user_id(user_id),
    .logged_in(logged_in), .auth_fail(auth_fail), .locked(locked),
    .fail_cnt(fail_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Credential ROM model, one-cycle registered read.
  function automatic logic [CW-1:0] rom_tbl(input logic [AW-1:0] a);
    case (a)
      3'd0: rom_tbl = 8'h11;
      3'd1: rom_tbl = 8'h22;
      3'd2: rom_tbl = 8'hA5;
      3'd3: rom_tbl = 8'h3C;
      default: rom_tbl = 8'h00;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_tbl(rom_addr);

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_enter(input logic [CW-1:0] v);
    enter = 1'b1;
    cred_in = v;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_logout();
    logout = 1'b1;
    tick();
    logout = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_outs", {logged_in, auth_fail, locked, busy}, 4'b0000);
    check("rst_fail", fail_cnt, 4'd0);
    check("rst_uid", user_id, 3'd0);
    check("rst_addr", rom_addr, 3'd0);
    tick();
    rst = 1'b0;
    tick();

    // Correct login
    pulse_enter(8'h02);
    check("ok_wait", state_dbg, ST_WAIT);
    check("ok_addr", rom_addr, 3'd2);
    pulse_enter(8'hA5);
    check("ok_busy1", busy, 1'b1);
    check("ok_noli1", logged_in, 1'b0);
    tick();
    check("ok_busy2", busy, 1'b1);
    check("ok_noli2", logged_in, 1'b0);
    tick();
    check("ok_li", logged_in, 1'b1);
    check("ok_uid", user_id, 3'd2);
    check("ok_busy0", busy, 1'b0);
    check("ok_fail", fail_cnt, 4'd0);
    pulse_enter(8'h01);
    check("gr_ign_enter", state_dbg, ST_GRANT);
    pulse_logout();
    check("lo_li", logged_in, 1'b0);
    check("lo_uid", user_id, 3'd0);
    check("lo_state", state_dbg, ST_IDLE);

    // Wrong password
    pulse_enter(8'h01);
    pulse_enter(8'h23);
    tick();
    check("wp_nofail_cmp", auth_fail, 1'b0);
    tick();
    check("wp_afail", auth_fail, 1'b1);
    check("wp_cnt", fail_cnt, 4'd1);
    check("wp_state", state_dbg, ST_IDLE);
    check("wp_li", logged_in, 1'b0);
    tick();
    check("wp_afail_1cyc", auth_fail, 1'b0);

    // Lockout after three failures
    do_reset();
    pulse_enter(8'h07);
    check("lk_inv_af", auth_fail, 1'b1);
    check("lk_inv_cnt", fail_cnt, 4'd1);
    check("lk_inv_st", state_dbg, ST_IDLE);
    tick();
    pulse_enter(8'h03);
    pulse_enter(8'h00);
    tick();
    tick();
    check("lk_f2_af", auth_fail, 1'b1);
    check("lk_f2_cnt", fail_cnt, 4'd2);
    check("lk_f2_lock", locked, 1'b0);
    pulse_enter(8'h00);
    pulse_enter(8'hFF);
    tick();
    tick();
    check("lk_f3_af", auth_fail, 1'b1);
    check("lk_f3_cnt", fail_cnt, 4'd3);
    check("lk_on", locked, 1'b1);
    seen_fail = 1'b0;
    for (int i = 1; i < 20; i++) begin
      enter = (i % 3 == 0);
      cred_in = 8'h03;
      tick();
      if (locked !== 1'b1 || state_dbg !== ST_LOCK) seen_fail = 1'b1;
    end
    enter = 1'b0;
    check("lk_held19", seen_fail, 1'b0);
    tick();
    check("lk_off", locked, 1'b0);
    check("lk_off_cnt", fail_cnt, 4'd0);
    check("lk_off_st", state_dbg, ST_IDLE);
    pulse_enter(8'h03);
    pulse_enter(8'h3C);
    tick();
    tick();
    check("lk_relog_li", logged_in, 1'b1);
    check("lk_relog_uid", user_id, 3'd3);
    pulse_logout();

    // Password timeout
    pulse_enter(8'h02);
    seen_fail = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (auth_fail !== 1'b0) seen_fail = 1'b1;
    end
    check("to_still_wait", state_dbg, ST_WAIT);
    tick();
    check("to_idle", state_dbg, ST_IDLE);
    check("to_no_af", seen_fail | auth_fail, 1'b0);
    check("to_cnt", fail_cnt, 4'd0);
    pulse_enter(8'hA5);
    check("to_inv_af", auth_fail, 1'b1);
    check("to_inv_cnt", fail_cnt, 4'd1);

    // Enter on the last timeout cycle wins
    tick();
    pulse_enter(8'h02);
    for (int i = 0; i < 49; i++) tick();
    pulse_enter(8'hA5);
    check("edge_fetch", state_dbg, ST_FETCH);
    tick();
    tick();
    check("edge_li", logged_in, 1'b1);
    check("edge_cnt", fail_cnt, 4'd0);
    pulse_logout();

    // Reset during CMP with a mismatch
    pulse_enter(8'h07);
    tick();
    check("rc_pre_cnt", fail_cnt, 4'd1);
    pulse_enter(8'h01);
    pulse_enter(8'h00);
    tick();
    check("rc_in_cmp", state_dbg, ST_CMP);
    #2;
    rst = 1'b1;
    #1;
    check("rc_outs", {logged_in, auth_fail, locked, busy}, 4'b0000);
    check("rc_cnt", fail_cnt, 4'd0);
    check("rc_state", state_dbg, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();
    check("rc_no_af", auth_fail, 1'b0);
    check("rc_cnt2", fail_cnt, 4'd0);

    // Two successes around one failure
    pulse_enter(8'h00);
    pulse_enter(8'h11);
    tick();
    tick();
    check("s1_li", logged_in, 1'b1);
    pulse_logout();
    pulse_enter(8'h02);
    pulse_enter(8'h00);
    tick();
    tick();
    check("s_mid_cnt", fail_cnt, 4'd1);
    pulse_enter(8'h01);
    pulse_enter(8'h22);
    tick();
    tick();
    check("s2_li", logged_in, 1'b1);
    check("s2_uid", user_id, 3'd1);
    check("s2_cnt", fail_cnt, 4'd0);
    pulse_logout();
    check("s2_lo", logged_in, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
